// File: rtl/cmd_out_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cmd_out_arbiter_pkg
//
// Shared pipeline types for the command-output arbitration slice.
//   byte_t       : one byte of a command stream
//   arb_state_e  : arbiter FSM state (IDLE / BUSY)
//   *_DEFAULT    : default parameter values for cmd_out_arbiter
//   wrap_next    : modulo-N increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package cmd_out_arbiter_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEFAULT         = 4;
  localparam int WATCHDOG_CYCLES_DEFAULT = 1024;

  // Width of the abort_id port; covers the full legal NUM_REQ range (up to 8).
  localparam int ABORT_ID_W  = 3;
  // Width of the mid-packet stall counter.
  localparam int STALL_CNT_W = 16;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cmd_out_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
//
// Rotating first-set search. Starting at bit 'start' and moving upward
// modulo N, reports the first set bit of 'mask'. Purely combinational.
//
// Parameters
//   N     : number of mask bits
//   IW    : width of start/index (at least $clog2(N))
// Ports
//   mask  : in,  candidate bits
//   start : in,  first position to examine
//   index : out, position of the first set bit found (0 when none)
//   found : out, 1 when any mask bit is set
// -----------------------------------------------------------------------------
module rr_priority_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] index,
  output logic          found
);

  // One spare bit so start + offset cannot overflow before the wrap.
  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit wins by being
  // written last; no priority-encoder chain is spelled out by hand.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, start} + (IW+1)'(i);
      if (pos >= N_W) begin
        pos = pos - N_W;
      end
      if (mask[pos[IW-1:0]]) begin
        found = 1'b1;
        index = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cmd_out_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_out_arbiter
//
// Packet-level round-robin arbiter merging NUM_REQ byte streams onto one
// command output stream. A grant is held from the first byte of a packet to
// the byte flagged with req_last, so packets never interleave. The output is
// a single registered stage: a byte accepted on cycle N is presented on
// cycle N+1, and one byte per cycle is sustained under continuous ready.
//
// Optional feature (macro CMD_OUT_ARB_WATCHDOG_EN):
//   When defined, a 16-bit stall counter watches the granted requester while
//   it withholds valid mid-packet. On reaching WATCHDOG_CYCLES-1 the packet is
//   aborted: the grant is dropped, abort_pulse fires for one cycle and
//   abort_id records the offender. When undefined, a stalled packet keeps the
//   grant indefinitely and abort_pulse/abort_id are tied to 0.
//
// Parameters
//   NUM_REQ         : number of requesters, 2..8
//   WATCHDOG_CYCLES : mid-packet stall limit in cycles, 2..65535
// Ports
//   clk           : in,  system clock
//   rstn          : in,  synchronous active-low reset
//   flush         : in,  synchronous abort (from the command reset)
//   req_valid     : in,  per-requester valid
//   req_ready     : out, per-requester ready (only the granted bit can be 1)
//   req_data      : in,  per-requester byte
//   req_last      : in,  per-requester end-of-packet marker
//   cmd_out_valid : out, output stream valid (registered)
//   cmd_out_ready : in,  output stream ready
//   cmd_out_data  : out, output stream byte (registered)
//   abort_pulse   : out, one-cycle pulse on a watchdog abort
//   abort_id      : out, index of the most recently aborted requester
// -----------------------------------------------------------------------------
module cmd_out_arbiter
  import cmd_out_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = NUM_REQ_DEFAULT,
  parameter int WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  byte_t [NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic                  cmd_out_valid,
  input  logic                  cmd_out_ready,
  output byte_t                 cmd_out_data,
  output logic                  abort_pulse,
  output logic [ABORT_ID_W-1:0] abort_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Elaboration-time guard on the legal parameter ranges.
  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      WATCHDOG_CYCLES < 2 || WATCHDOG_CYCLES > 65535) begin : g_bad_params
    $error("cmd_out_arbiter: NUM_REQ or WATCHDOG_CYCLES out of range");
  end

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt;
  logic             out_full;
  byte_t            out_data;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [IDX_W-1:0] next_ptr;

  logic             gnt_valid;
  logic             gnt_last;
  byte_t            gnt_data;
  logic             in_ready;
  logic             in_xfer;

  // ---------------------------------------------------------------------------
  // Requester selection
  // ---------------------------------------------------------------------------
  rr_priority_select #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_select (
    .mask  (req_valid),
    .start (rr_ptr),
    .index (sel_idx),
    .found (sel_found)
  );

  assign next_ptr = IDX_W'(wrap_next(int'(gnt), NUM_REQ));

  // ---------------------------------------------------------------------------
  // Input handshake
  // ---------------------------------------------------------------------------
  assign gnt_valid = req_valid[gnt];
  assign gnt_last  = req_last[gnt];
  assign gnt_data  = req_data[gnt];

  // Ready follows downstream ready combinationally (ready-to-ready only); the
  // output valid is a pure register, so no valid depends on any ready.
  // flush masks ready so nothing is accepted on the flush cycle.
  assign in_ready  = (state == BUSY) && !flush && (!out_full || cmd_out_ready);
  assign in_xfer   = in_ready && gnt_valid;
  assign req_ready = in_ready ? (NUM_REQ'(1) << gnt) : '0;

  assign cmd_out_valid = out_full;
  assign cmd_out_data  = out_data;

`ifdef CMD_OUT_ARB_WATCHDOG_EN
  // ---------------------------------------------------------------------------
  // Mid-packet stall watchdog
  // ---------------------------------------------------------------------------
  localparam logic [STALL_CNT_W-1:0] WD_LIMIT = STALL_CNT_W'(WATCHDOG_CYCLES - 1);

  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [STALL_CNT_W-1:0] cnt_inc;
  logic                   wd_expire;

  assign cnt_inc = stall_cnt + 1'b1;
  // Expiry is taken on the stall cycle that would carry the count to the
  // limit; the granted requester is idle then, so no byte can be in flight.
  assign wd_expire = (state == BUSY) && !gnt_valid && (cnt_inc == WD_LIMIT);
`else
  assign abort_pulse = 1'b0;
  assign abort_id    = '0;
`endif

  // ---------------------------------------------------------------------------
  // Arbiter FSM and output register
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      out_full <= 1'b0;
      // NOTE: the output data register is reset as well, so cmd_out_data
      // reads a defined 0 out of reset rather than whatever powered up.
      out_data <= '0;
`ifdef CMD_OUT_ARB_WATCHDOG_EN
      stall_cnt   <= '0;
      abort_pulse <= 1'b0;
      abort_id    <= '0;
`endif
    end else begin
`ifdef CMD_OUT_ARB_WATCHDOG_EN
      abort_pulse <= 1'b0;
`endif

      // One-entry output stage. A new byte may replace the current one on
      // the same cycle it is consumed, which gives full throughput. An abort
      // leaves this stage alone so a byte already captured is still sent.
      if (flush) begin
        out_full <= 1'b0;
      end else if (in_xfer) begin
        out_full <= 1'b1;
        out_data <= gnt_data;
      end else if (cmd_out_ready) begin
        out_full <= 1'b0;
      end

      if (flush) begin
        // rr_ptr and gnt are deliberately kept; flush outranks expiry, so no
        // abort is reported on the same cycle.
        state <= IDLE;
`ifdef CMD_OUT_ARB_WATCHDOG_EN
        stall_cnt <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (sel_found) begin
              gnt   <= sel_idx;
              state <= BUSY;
`ifdef CMD_OUT_ARB_WATCHDOG_EN
              stall_cnt <= '0;
`endif
            end
          end

          BUSY: begin
            if (in_xfer) begin
`ifdef CMD_OUT_ARB_WATCHDOG_EN
              stall_cnt <= '0;
`endif
              if (gnt_last) begin
                state  <= IDLE;
                rr_ptr <= next_ptr;
              end
            end
`ifdef CMD_OUT_ARB_WATCHDOG_EN
            else if (wd_expire) begin
              state       <= IDLE;
              rr_ptr      <= next_ptr;
              stall_cnt   <= '0;
              abort_pulse <= 1'b1;
              abort_id    <= ABORT_ID_W'(gnt);
            end else if (!gnt_valid) begin
              stall_cnt <= cnt_inc;
            end
`endif
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
